// File: rtl/vx_raster_stamp_loader_pkg.sv
// Shared types, sizes and helpers for the rasterizer stamp loader: stamp/CSR payloads,
// CSR index map, FSM states and the unpack / CSR word select functions.
package vx_raster_stamp_loader_pkg;

  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned DIM_BITS    = 15;
  localparam int unsigned POS_W       = DIM_BITS - 1;
  localparam int unsigned MASK_W      = 4;
  localparam int unsigned PID_W       = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_BC      = 4;
  localparam int unsigned CSR_AW      = 4;
  localparam int unsigned WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned ENTRIES     = NUM_WARPS * NUM_THREADS;
  localparam int unsigned ENTRY_AW    = WID_W + TID_W;

  localparam logic [CSR_AW-1:0] RASTER_CSR_POS_MASK = 4'd0;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCX0     = 4'd1;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCX1     = 4'd2;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCX2     = 4'd3;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCX3     = 4'd4;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCY0     = 4'd5;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCY1     = 4'd6;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCY2     = 4'd7;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCY3     = 4'd8;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCZ0     = 4'd9;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCZ1     = 4'd10;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCZ2     = 4'd11;
  localparam logic [CSR_AW-1:0] RASTER_CSR_BCZ3     = 4'd12;

  typedef struct packed {
    logic [POS_W-1:0]              pos_x;
    logic [POS_W-1:0]              pos_y;
    logic [MASK_W-1:0]             mask;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_x;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_y;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_z;
    logic [PID_W-1:0]              pid;
  } raster_stamp_t;

  typedef struct packed {
    logic [DATA_W-1:0]             pos_mask;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_x;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_y;
    logic [NUM_BC-1:0][DATA_W-1:0] bcoord_z;
  } raster_csrs_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Primitive id is not visible to the shader, so it is dropped here.
  function automatic raster_csrs_t unpack_stamp(input raster_stamp_t s);
    raster_csrs_t c;
    c.pos_mask = {s.pos_y, s.pos_x, s.mask};
    c.bcoord_x = s.bcoord_x;
    c.bcoord_y = s.bcoord_y;
    c.bcoord_z = s.bcoord_z;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] csr_word(input raster_csrs_t e, input logic [CSR_AW-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    case (a)
      RASTER_CSR_POS_MASK: w = e.pos_mask;
      RASTER_CSR_BCX0:     w = e.bcoord_x[0];
      RASTER_CSR_BCX1:     w = e.bcoord_x[1];
      RASTER_CSR_BCX2:     w = e.bcoord_x[2];
      RASTER_CSR_BCX3:     w = e.bcoord_x[3];
      RASTER_CSR_BCY0:     w = e.bcoord_y[0];
      RASTER_CSR_BCY1:     w = e.bcoord_y[1];
      RASTER_CSR_BCY2:     w = e.bcoord_y[2];
      RASTER_CSR_BCY3:     w = e.bcoord_y[3];
      RASTER_CSR_BCZ0:     w = e.bcoord_z[0];
      RASTER_CSR_BCZ1:     w = e.bcoord_z[1];
      RASTER_CSR_BCZ2:     w = e.bcoord_z[2];
      RASTER_CSR_BCZ3:     w = e.bcoord_z[3];
      default:             w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [TID_W-1:0] lowest_idx(input logic [NUM_THREADS-1:0] m);
    logic [TID_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
      if (m[i]) idx = TID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_raster_stamp_loader_csr_store.sv
// Per-(warp,thread) raster CSR storage: one write port, one registered 32-bit read port.
// A read and write to the same entry in one cycle returns the pre-write contents.
module vx_raster_stamp_loader_csr_store
  import vx_raster_stamp_loader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [ENTRY_AW-1:0] wr_entry_i,
  input  raster_csrs_t        wr_data_i,
  input  logic                rd_valid_i,
  input  logic [ENTRY_AW-1:0] rd_entry_i,
  input  logic [CSR_AW-1:0]   rd_csr_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  raster_csrs_t      mem_q [ENTRIES];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ENTRIES); i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_entry_i] <= wr_data_i;
    end
  end

  // Read data holds between strobes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_valid_i) rd_data_d = csr_word(mem_q[rd_entry_i], rd_csr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vx_raster_stamp_loader.sv
// Rasterizer stamp consumer: fills one warp's per-thread CSR entries from the stamp
// stream on request, reports which threads were filled, and serves shader CSR reads.
module vx_raster_stamp_loader
  import vx_raster_stamp_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stamp_valid_i,
  input  raster_stamp_t          stamp_data_i,
  input  logic                   stamp_done_i,
  output logic                   stamp_ready_o,
  input  logic                   req_valid_i,
  input  logic [WID_W-1:0]       req_wid_i,
  input  logic [NUM_THREADS-1:0] req_tmask_i,
  output logic                   req_ready_o,
  output logic                   rsp_valid_o,
  output logic [WID_W-1:0]       rsp_wid_o,
  output logic [NUM_THREADS-1:0] rsp_tmask_o,
  input  logic                   rsp_ready_i,
  input  logic                   csr_rd_valid_i,
  input  logic [WID_W-1:0]       csr_rd_wid_i,
  input  logic [TID_W-1:0]       csr_rd_tid_i,
  input  logic [CSR_AW-1:0]      csr_rd_addr_i,
  output logic [DATA_W-1:0]      csr_rd_data_o
);

  state_e                 state_q, state_d;
  logic [WID_W-1:0]       wid_q, wid_d;
  logic [NUM_THREADS-1:0] pending_q, pending_d;
  logic [NUM_THREADS-1:0] filled_q, filled_d;
  logic                   req_ready_q, req_ready_d;
  logic [NUM_THREADS-1:0] low_bit_c;
  logic [TID_W-1:0]       wr_tid_c;
  logic                   wr_en_c;
  logic                   stamp_fire_c;
  logic                   unused_pid;

  assign unused_pid    = ^stamp_data_i.pid;
  assign stamp_ready_o = (state_q == ST_FILL) && (pending_q != '0);
  assign stamp_fire_c  = stamp_valid_i && stamp_ready_o;
  assign low_bit_c     = pending_q & ~(pending_q - NUM_THREADS'(1));
  assign wr_tid_c      = lowest_idx(pending_q);

  always_comb begin
    state_d   = state_q;
    wid_d     = wid_q;
    pending_d = pending_q;
    filled_d  = filled_q;
    wr_en_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          wid_d     = req_wid_i;
          pending_d = req_tmask_i;
          filled_d  = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (stamp_fire_c) begin
          wr_en_c   = 1'b1;
          pending_d = pending_q & ~low_bit_c;
          filled_d  = filled_q | low_bit_c;
        end
        // A stamp arriving alongside done is consumed before giving up on the rest.
        if ((pending_d == '0) || (stamp_done_i && !stamp_valid_i)) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // req_ready is registered so it stays low while reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wid_q       <= '0;
      pending_q   <= '0;
      filled_q    <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wid_q       <= wid_d;
      pending_q   <= pending_d;
      filled_q    <= filled_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_wid_o   = wid_q;
  assign rsp_tmask_o = filled_q;

  vx_raster_stamp_loader_csr_store u_store (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (wr_en_c),
    .wr_entry_i (ENTRY_AW'({wid_q, wr_tid_c})),
    .wr_data_i  (unpack_stamp(stamp_data_i)),
    .rd_valid_i (csr_rd_valid_i),
    .rd_entry_i (ENTRY_AW'({csr_rd_wid_i, csr_rd_tid_i})),
    .rd_csr_i   (csr_rd_addr_i),
    .rd_data_o  (csr_rd_data_o)
  );

endmodule
